// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor: FSM state type,
// state encodings and the bit-counter width helper.
package serial_sub_pkg;

    localparam int DEF_WIDTH = 4;

    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

    localparam int CNT_W = cnt_width(DEF_WIDTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        DONE = ST_DONE
    } state_e;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: diff = x - y - bw_in, with borrow out.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bw_in,
    output logic diff,
    output logic bw_out
);

    assign diff   = x ^ y ^ bw_in;
    assign bw_out = (~x & y) | (~(x ^ y) & bw_in);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, d = a - b - bin computed LSB first through a
// single full-subtractor cell. Define OVF_FLAG_EN to add the signed-overflow output.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             bout
`ifdef OVF_FLAG_EN
    ,
    output logic             ovf
`endif
);

    // The package constant already covers the default width.
    localparam int CW = (WIDTH == DEF_WIDTH) ? CNT_W : cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             borrow_q, borrow_d;
    logic             fs_diff;
    logic             fs_bw;
`ifdef OVF_FLAG_EN
    logic             ovf_q, ovf_d;
`endif

    full_subtractor u_fs (
        .x      (a_q[0]),
        .y      (b_q[0]),
        .bw_in  (borrow_q),
        .diff   (fs_diff),
        .bw_out (fs_bw)
    );

    // NOTE: every signal written here gets its default first, so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        d_d      = d_q;
        cnt_d    = cnt_q;
        borrow_d = borrow_q;
`ifdef OVF_FLAG_EN
        ovf_d    = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d      = a;
                    b_d      = b;
                    borrow_d = bin;
                    cnt_d    = '0;
                    d_d      = '0;
`ifdef OVF_FLAG_EN
                    ovf_d    = 1'b0;
`endif
                    state_d  = RUN;
                end
            end
            RUN: begin
                // Operands shift right so the cell always sees the current bit at index 0.
                a_d          = a_q >> 1;
                b_d          = b_q >> 1;
                d_d[cnt_q]   = fs_diff;
                borrow_d     = fs_bw;
                cnt_d        = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
`ifdef OVF_FLAG_EN
                    // On the last bit the cell inputs are the operand sign bits.
                    ovf_d   = (a_q[0] ^ b_q[0]) & (fs_diff ^ a_q[0]);
`endif
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
`ifdef OVF_FLAG_EN
                    ovf_d   = 1'b0;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            d_q      <= '0;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
`ifdef OVF_FLAG_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            d_q      <= d_d;
            cnt_q    <= cnt_d;
            borrow_q <= borrow_d;
`ifdef OVF_FLAG_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    // NOTE: operand shift registers carry no reset; they are always reloaded on accept.
    always_ff @(posedge clk) begin
        a_q <= a_d;
        b_q <= b_d;
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign d         = d_q;
    assign bout      = borrow_q;
`ifdef OVF_FLAG_EN
    assign ovf       = ovf_q;
`endif

endmodule
